// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One outstanding request; the request completes on the cycle imem_ready is high.
interface instr_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// Pipeline instruction fetch: PC sequencing, one-entry skid buffer for stalls,
// redirect handling with discard of an in-flight request, and the IF/ID register.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        stall,
   input  logic                        redirect,
   input  logic [31:0]                 redirect_target,
   instr_fetch_stage_if.master         imem,
   output logic                        if_id_valid,
   output logic [31:0]                 if_id_pc,
   output logic [31:0]                 if_id_instr
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
   logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
   logic [XLEN-1:0]   pend_q, pend_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
   logic              req_q, req_d;
   logic              bubble;
   logic [XLEN-1:0]   target;

   assign target = {redirect_target[XLEN-1:2], 2'b00};

   // Next-state, PC sequencing and IF/ID load decisions
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      pend_d       = pend_q;
      valid_d      = valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      bubble       = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect) pc_d = target;
            bubble = redirect || !stall;
         end
         FETCH: begin
            if (redirect) begin
               if (imem.imem_ready) begin
                  pc_d = target;
               end else begin
                  pend_d  = target;
                  state_d = DISCARD;
               end
               bubble = 1'b1;
            end else if (imem.imem_ready) begin
               pc_d = pc_q + XLEN'(4);
               if (stall) begin
                  skid_pc_d    = pc_q;
                  skid_instr_d = imem.imem_rdata;
                  state_d      = HOLD;
               end else begin
                  valid_d      = 1'b1;
                  ifid_pc_d    = pc_q;
                  ifid_instr_d = imem.imem_rdata;
               end
            end else begin
               bubble = !stall;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d         = target;
               skid_pc_d    = '0;
               skid_instr_d = '0;
               state_d      = FETCH;
               bubble       = 1'b1;
            end else if (!stall) begin
               valid_d      = 1'b1;
               ifid_pc_d    = skid_pc_q;
               ifid_instr_d = skid_instr_q;
               state_d      = FETCH;
            end
         end
         DISCARD: begin
            // A redirect arriving with the response wins over the older pending target
            if (imem.imem_ready) begin
               pc_d    = redirect ? target : pend_q;
               state_d = FETCH;
            end else if (redirect) begin
               pend_d = target;
            end
            bubble = redirect || !stall;
         end
         default: state_d = IDLE;
      endcase

      if (bubble) begin
         valid_d      = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end
   end

   assign req_d = (state_d == FETCH) || (state_d == DISCARD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         pend_q       <= '0;
         valid_q      <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         req_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         pend_q       <= pend_d;
         valid_q      <= valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         req_q        <= req_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign if_id_valid    = valid_q;
   assign if_id_pc       = ifid_pc_q;
   assign if_id_instr    = ifid_instr_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized and directed bench for instr_fetch_stage against a flag-based
// behavioural model of the fetch pipeline and an address-derived memory.
module tb_instr_fetch_stage;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] MEM_XOR   = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;

   instr_fetch_stage_if bus ();

   instr_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem            (bus),
      .if_id_valid     (if_id_valid),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Model: fetch progress is tracked as a few flags rather than a state machine
   bit          m_just_reset, m_have_skid, m_dropping;
   logic [31:0] m_pc, m_pending, m_skid_pc, m_skid_instr;
   logic        m_valid;
   logic [31:0] m_ifid_pc, m_ifid_instr;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
   endtask

   function automatic bit m_req();
      return !m_just_reset && !m_have_skid;
   endfunction

   task automatic m_reset();
      m_just_reset = 1'b1; m_have_skid = 1'b0; m_dropping = 1'b0;
      m_pc = RESET_PC; m_pending = '0; m_skid_pc = '0; m_skid_instr = '0;
      m_valid = 1'b0; m_ifid_pc = '0; m_ifid_instr = NOP_INSTR;
   endtask

   task automatic m_bubble();
      m_valid = 1'b0; m_ifid_instr = NOP_INSTR;
   endtask

   // One clock edge of the reference behaviour
   task automatic m_edge(input bit st, input bit rd, input logic [31:0] tg, input bit rdy);
      logic [31:0] t;
      logic [31:0] word;
      t    = tg & 32'hFFFF_FFFC;
      word = m_pc ^ MEM_XOR;
      if (m_just_reset) begin
         m_just_reset = 1'b0;
         if (rd) m_pc = t;
         if (rd || !st) m_bubble();
      end else if (m_have_skid) begin
         if (rd) begin
            m_have_skid = 1'b0; m_pc = t; m_bubble();
         end else if (!st) begin
            m_have_skid = 1'b0;
            m_valid = 1'b1; m_ifid_pc = m_skid_pc; m_ifid_instr = m_skid_instr;
         end
      end else if (m_dropping) begin
         if (rdy) begin
            m_dropping = 1'b0;
            m_pc = rd ? t : m_pending;
         end else if (rd) begin
            m_pending = t;
         end
         if (rd || !st) m_bubble();
      end else begin
         if (rd) begin
            if (rdy) m_pc = t;
            else begin m_dropping = 1'b1; m_pending = t; end
            m_bubble();
         end else if (rdy) begin
            if (st) begin
               m_have_skid = 1'b1; m_skid_pc = m_pc; m_skid_instr = word;
            end else begin
               m_valid = 1'b1; m_ifid_pc = m_pc; m_ifid_instr = word;
            end
            m_pc = m_pc + 32'd4;
         end else if (!st) begin
            m_bubble();
         end
      end
   endtask

   task automatic compare();
      check("imem_req", 32'(bus.imem_req), 32'(m_req()));
      if (m_req()) check("imem_addr", bus.imem_addr, m_pc);
      check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check("if_id_pc", if_id_pc, m_ifid_pc);
      check("if_id_instr", if_id_instr, m_ifid_instr);
   endtask

   // Drive one cycle from a negedge; memory answers only a live request
   task automatic step(input bit st, input bit rd, input logic [31:0] tg, input bit rdy);
      bit r;
      r = rdy && bus.imem_req;
      stall           = st;
      redirect        = rd;
      redirect_target = tg;
      bus.imem_ready  = r;
      bus.imem_rdata  = r ? (bus.imem_addr ^ MEM_XOR) : $urandom();
      m_edge(st, rd, tg, r);
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
      bus.imem_ready = 1'b0; bus.imem_rdata = '0;
      m_reset();
      repeat (2) @(negedge clk);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_valid", 32'(if_id_valid), 32'd0);
      check("rst_pc", if_id_pc, 32'd0);
      check("rst_instr", if_id_instr, NOP_INSTR);
      reset_n = 1'b1;

      // Leave reset, then zero-wait streaming
      step(0, 0, '0, 1);
      check("first_addr", bus.imem_addr, RESET_PC);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, '0, 1);
         check("stream_pc", if_id_pc, 32'(i * 4));
      end
      // Slow memory: bubbles while the address is held
      repeat (3) begin
         step(0, 0, '0, 0);
         check("wait_addr", bus.imem_addr, 32'h10);
      end
      step(0, 0, '0, 1);
      // Stall as a response lands, then release
      step(1, 0, '0, 1);
      check("hold_req", 32'(bus.imem_req), 32'd0);
      step(1, 0, '0, 0);
      step(0, 0, '0, 0);
      // Redirect with a request pending, misaligned target
      step(0, 1, 32'h0000_0103, 0);
      check("redir_bubble", 32'(if_id_valid), 32'd0);
      step(0, 0, '0, 0);
      step(0, 0, '0, 1);
      check("redir_addr", bus.imem_addr, 32'h100);
      // Redirect together with stall
      step(1, 1, 32'h0000_0040, 1);
      check("stall_redir_addr", bus.imem_addr, 32'h40);
      check("stall_redir_valid", 32'(if_id_valid), 32'd0);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom(),
              $urandom_range(0, 9) < 6);
      end

      // Asynchronous reset while discarding an outstanding request
      step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      step(0, 1, 32'h0000_0200, 0);
      check("in_discard", 32'(m_dropping), 32'd1);
      #2 reset_n = 1'b0;
      m_reset();
      #1;
      check("arst_req", 32'(bus.imem_req), 32'd0);
      check("arst_valid", 32'(if_id_valid), 32'd0);
      check("arst_pc", if_id_pc, 32'd0);
      check("arst_instr", if_id_instr, NOP_INSTR);
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, '0, 1);
      check("restart_addr", bus.imem_addr, RESET_PC);
      repeat (6) step(0, 0, '0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
